// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the ControlUnit, fetch_decode_unit and their benches:
// opcodes, PC-source encodings, instruction field positions and the fetch FSM states.
package cpu_isa_pkg;

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h01;
    localparam logic [5:0] OP_ADD  = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h03;
    localparam logic [5:0] OP_SUB  = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h06;
    localparam logic [5:0] OP_BEQ  = 6'h07;
    localparam logic [5:0] OP_BNE  = 6'h08;
    localparam logic [5:0] OP_JMP  = 6'h09;
    localparam logic [5:0] OP_CALL = 6'h0A;
    localparam logic [5:0] OP_RET  = 6'h0B;
    localparam logic [5:0] OP_NOP  = 6'h0C;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
    localparam logic [1:0] PC_SRC_RET    = 2'd3;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_MSB = 21;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_MSB = 17;
    localparam int unsigned RS2_LSB = 14;
    localparam int unsigned IMM_MSB = 13;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } fdu_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_ADDI, OP_SUB, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_RET, OP_NOP: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fdu_next_pc.sv
// Next-instruction-address multiplexer; the sequential path wraps from all-ones to zero.
module fdu_next_pc
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [1:0]        pc_src_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] return_addr_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        next_pc_o = pc_i + One;
        unique case (pc_src_i)
            PC_SRC_INC:    next_pc_o = pc_i + One;
            PC_SRC_JUMP:   next_pc_o = jump_target_i;
            PC_SRC_BRANCH: next_pc_o = branch_target_i;
            PC_SRC_RET:    next_pc_o = return_addr_i;
            default:       next_pc_o = pc_i + One;
        endcase
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode companion of the multi-cycle ControlUnit: PC, IR, imem handshake, field split.
// Optional build macro FDU_ILLEGAL_TRAP_EN maps unknown opcodes to NOP and adds illegal_op.
module fetch_decode_unit
    import cpu_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en_instruction_fetch,
    input  logic              en_instruction_decode,
    input  logic [1:0]        sig_pc_src,
    input  logic              ext_op,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] return_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [5:0]        FunctionCode,
    output logic [3:0]        rd,
    output logic [3:0]        rs1,
    output logic [3:0]        rs2,
    output logic [31:0]       imm_ext,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              fetch_done,
    output logic              protocol_err
`ifdef FDU_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

    fdu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              first_q, first_d;
    logic              req_q, req_d;
    logic [31:0]       ir_q, ir_d;
    logic [5:0]        fc_q, fc_d;
    logic [3:0]        rd_q, rd_d;
    logic [3:0]        rs1_q, rs1_d;
    logic [3:0]        rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic [ADDR_W-1:0] mux_pc;
    logic [ADDR_W-1:0] next_addr;
    logic [5:0]        ir_op;
`ifdef FDU_ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    fdu_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_i            (pc_q),
        .pc_src_i        (sig_pc_src),
        .jump_target_i   (jump_target),
        .branch_target_i (branch_target),
        .return_addr_i   (return_addr),
        .next_pc_o       (mux_pc)
    );

    // The very first fetch after reset ignores the PC-source select.
    assign next_addr = first_q ? RESET_PC : mux_pc;
    assign ir_op     = ir_q[OPC_MSB:OPC_LSB];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        first_d = first_q;
        req_d   = req_q;
        ir_d    = ir_q;
        fc_d    = fc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
`ifdef FDU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        // Decode reads ir_q, so a same-cycle fetch in HOLD still decodes the old word.
        if (en_instruction_decode) begin
            if (state_q == StHold) begin
                fc_d  = ir_op;
                rd_d  = ir_q[RD_MSB:RD_LSB];
                rs1_d = ir_q[RS1_MSB:RS1_LSB];
                rs2_d = ir_q[RS2_MSB:RS2_LSB];
                imm_d = ext_op ? {{(32-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]}
                               : {{(32-IMM_W){1'b0}}, ir_q[IMM_MSB:IMM_LSB]};
`ifdef FDU_ILLEGAL_TRAP_EN
                illegal_d = !is_legal_op(ir_op);
                if (!is_legal_op(ir_op)) begin
                    fc_d = OP_NOP;
                end
`endif
            end else begin
                perr_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StHold: begin
                if (en_instruction_fetch) begin
                    pc_d    = next_addr;
                    addr_d  = next_addr;
                    req_d   = 1'b1;
                    first_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (en_instruction_fetch) begin
                    perr_d = 1'b1;
                end
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StHold;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            first_q <= 1'b1;
            req_q   <= 1'b0;
            ir_q    <= '0;
            fc_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            req_q   <= req_d;
            ir_q    <= ir_d;
            fc_q    <= fc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

`ifdef FDU_ILLEGAL_TRAP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`endif

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign FunctionCode = fc_q;
    assign rd           = rd_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign imm_ext      = imm_q;
    assign pc           = pc_q;
    assign pc_plus1     = pc_q + One;
    assign fetch_done   = done_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: expected addresses and decode fields are queued at
// stimulus time and popped when the DUT presents them. Honours FDU_ILLEGAL_TRAP_EN.
module tb_fetch_decode_unit;
    import cpu_isa_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        en_instruction_fetch, en_instruction_decode, ext_op, imem_ack;
    logic [1:0]  sig_pc_src;
    logic [31:0] jump_target, branch_target, return_addr, imem_rdata;
    logic        imem_req, fetch_done, protocol_err;
    logic [31:0] imem_addr, imm_ext, pc, pc_plus1;
    logic [5:0]  FunctionCode;
    logic [3:0]  rd, rs1, rs2;
`ifdef FDU_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    typedef struct {
        logic [5:0]  fc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    logic [31:0] addr_sb[$];
    dec_t        dec_sb[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    logic [31:0] model_pc    = RESET_PC;
    logic        model_first = 1'b1;
    logic [31:0] model_ir    = 32'h0;

    always #5 clock = ~clock;

    fetch_decode_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .en_instruction_fetch  (en_instruction_fetch),
        .en_instruction_decode (en_instruction_decode),
        .sig_pc_src            (sig_pc_src),
        .ext_op                (ext_op),
        .jump_target           (jump_target),
        .branch_target         (branch_target),
        .return_addr           (return_addr),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_ack              (imem_ack),
        .imem_rdata            (imem_rdata),
        .FunctionCode          (FunctionCode),
        .rd                    (rd),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .imm_ext               (imm_ext),
        .pc                    (pc),
        .pc_plus1              (pc_plus1),
        .fetch_done            (fetch_done),
        .protocol_err          (protocol_err)
`ifdef FDU_ILLEGAL_TRAP_EN
        ,
        .illegal_op            (illegal_op)
`endif
    );

    function automatic logic [31:0] model_na(input logic [1:0] src);
        if (model_first) return RESET_PC;
        case (src)
            2'd0:    return model_pc + 32'd1;
            2'd1:    return jump_target;
            2'd2:    return branch_target;
            default: return return_addr;
        endcase
    endfunction

    function automatic dec_t model_decode(input logic [31:0] w, input bit ext);
        dec_t d;
        d.fc  = w[31:26];
        d.rd  = w[25:22];
        d.rs1 = w[21:18];
        d.rs2 = w[17:14];
        d.imm = ext ? {{18{w[13]}}, w[13:0]} : {18'h0, w[13:0]};
        d.ill = 1'b0;
`ifdef FDU_ILLEGAL_TRAP_EN
        if (w[31:26] > 6'h0C) begin
            d.fc  = OP_NOP;
            d.ill = 1'b1;
        end
`endif
        return d;
    endfunction

    // Scoreboard consumer: pops the oldest expected decode and compares it with the outputs.
    task automatic sb_check_decode(input string tag);
        dec_t e;
        if (dec_sb.size() == 0) begin
            $display("FAIL %s: decode scoreboard empty", tag);
            n_chk++;
            return;
        end
        e = dec_sb.pop_front();
        if (FunctionCode !== e.fc) $display("FAIL %s.fc: got %h want %h", tag, FunctionCode, e.fc);
        else n_pass++;
        n_chk++;
        if ({rd, rs1, rs2} !== {e.rd, e.rs1, e.rs2})
            $display("FAIL %s.regs: got %h/%h/%h want %h/%h/%h", tag, rd, rs1, rs2,
                     e.rd, e.rs1, e.rs2);
        else n_pass++;
        n_chk++;
        if (imm_ext !== e.imm) $display("FAIL %s.imm: got %h want %h", tag, imm_ext, e.imm);
        else n_pass++;
        n_chk++;
`ifdef FDU_ILLEGAL_TRAP_EN
        if (illegal_op !== e.ill) $display("FAIL %s.ill: got %b want %b", tag, illegal_op, e.ill);
        else n_pass++;
        n_chk++;
`endif
    endtask

    task automatic do_decode(input bit ext, input string tag);
        dec_sb.push_back(model_decode(model_ir, ext));
        ext_op = ext;
        en_instruction_decode = 1'b1;
        @(posedge clock); #1;
        en_instruction_decode = 1'b0;
        sb_check_decode(tag);
    endtask

    task automatic do_fetch(input logic [1:0] src, input logic [31:0] word, input int delay,
                            input bit stray, input bit with_dec, input bit ext, input string tag);
        logic [31:0] exp_addr;
        addr_sb.push_back(model_na(src));
        if (with_dec) begin
            dec_sb.push_back(model_decode(model_ir, ext));
            ext_op = ext;
            en_instruction_decode = 1'b1;
        end
        sig_pc_src = src;
        en_instruction_fetch = 1'b1;
        @(posedge clock); #1;
        en_instruction_fetch = 1'b0;
        en_instruction_decode = 1'b0;
        if (with_dec) sb_check_decode({tag, ".dec"});
        exp_addr = addr_sb.pop_front();
        if (imem_req !== 1'b1) $display("FAIL %s.req: got %b want 1", tag, imem_req);
        else n_pass++;
        n_chk++;
        if (imem_addr !== exp_addr) $display("FAIL %s.addr: got %h want %h", tag, imem_addr, exp_addr);
        else n_pass++;
        n_chk++;
        if (pc !== exp_addr) $display("FAIL %s.pc: got %h want %h", tag, pc, exp_addr);
        else n_pass++;
        n_chk++;
        for (int i = 0; i < delay; i++) begin
            if (stray && i == 1) begin
                sig_pc_src = 2'd1;
                en_instruction_fetch = 1'b1;
            end
            @(posedge clock); #1;
            en_instruction_fetch = 1'b0;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || fetch_done !== 1'b0)
                $display("FAIL %s.wait%0d: req=%b addr=%h done=%b want 1/%h/0", tag, i,
                         imem_req, imem_addr, fetch_done, exp_addr);
            else n_pass++;
            n_chk++;
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(posedge clock); #1;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (fetch_done !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL %s.done: done=%b req=%b want 1/0", tag, fetch_done, imem_req);
        else n_pass++;
        n_chk++;
        model_pc = exp_addr;
        model_first = 1'b0;
        model_ir = word;
        @(posedge clock); #1;
        if (fetch_done !== 1'b0) $display("FAIL %s.pulse: done=%b want 0", tag, fetch_done);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        en_instruction_fetch = 0; en_instruction_decode = 0; sig_pc_src = 0; ext_op = 0;
        jump_target = 0; branch_target = 0; return_addr = 0; imem_ack = 0; imem_rdata = 0;
        #12;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc !== RESET_PC)
            $display("FAIL reset.fetch: req=%b addr=%h pc=%h want 0/%h/%h", imem_req, imem_addr,
                     pc, RESET_PC, RESET_PC);
        else n_pass++;
        n_chk++;
        if ({FunctionCode, rd, rs1, rs2, imm_ext} !== 50'h0 || fetch_done !== 1'b0 ||
            protocol_err !== 1'b0)
            $display("FAIL reset.decode: fc=%h imm=%h done=%b perr=%b want zeros", FunctionCode,
                     imm_ext, fetch_done, protocol_err);
        else n_pass++;
        n_chk++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_first_fetch;
        do_fetch(2'd3, 32'h0C40_2005, 0, 1'b0, 1'b0, 1'b0, "first");
        do_decode(1'b0, "first.dec0");
        do_decode(1'b1, "first.dec1");
    endtask

    task automatic test_imm_ext;
        do_fetch(2'd0, 32'h0C00_3FFF, 0, 1'b0, 1'b0, 1'b0, "imm");
        do_decode(1'b1, "imm.sext");
        do_decode(1'b0, "imm.zext");
    endtask

    task automatic test_pc_src;
        jump_target = 32'd5;
        do_fetch(2'd1, 32'h0880_4000, 0, 1'b0, 1'b0, 1'b0, "pc5");
        do_fetch(2'd0, 32'h1000_0001, 0, 1'b0, 1'b0, 1'b0, "inc");
        jump_target = 32'd40;
        do_fetch(2'd1, 32'h1400_0002, 1, 1'b0, 1'b0, 1'b0, "jump");
        branch_target = 32'd7;
        do_fetch(2'd2, 32'h1C00_0003, 0, 1'b0, 1'b0, 1'b0, "branch");
        return_addr = 32'd6;
        do_fetch(2'd3, 32'h2C00_0004, 0, 1'b0, 1'b0, 1'b0, "ret");
    endtask

    task automatic test_wait_protocol;
        if (protocol_err !== 1'b0) $display("FAIL perr.pre: got %b want 0", protocol_err);
        else n_pass++;
        n_chk++;
        jump_target = 32'h0000_1234;
        do_fetch(2'd0, 32'h0951_8123, 3, 1'b1, 1'b0, 1'b0, "wait");
        if (protocol_err !== 1'b1) $display("FAIL perr.stray: got %b want 1", protocol_err);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_wrap;
        jump_target = 32'hFFFF_FFFF;
        do_fetch(2'd1, 32'h0800_0000, 0, 1'b0, 1'b0, 1'b0, "top");
        if (pc_plus1 !== 32'h0) $display("FAIL wrap.pc_plus1: got %h want 0", pc_plus1);
        else n_pass++;
        n_chk++;
        do_fetch(2'd0, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_back_to_back;
        // Decode of the current IR and the next fetch in the same HOLD cycle.
        do_fetch(2'd0, 32'h2000_0000, 0, 1'b0, 1'b1, 1'b1, "b2b");
        do_decode(1'b0, "b2b.new");
    endtask

    task automatic test_reset_mid;
        sig_pc_src = 2'd0;
        en_instruction_fetch = 1'b1;
        @(posedge clock); #1;
        en_instruction_fetch = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        if (imem_req !== 1'b0 || pc !== RESET_PC || FunctionCode !== 6'h0)
            $display("FAIL rstmid.async: req=%b pc=%h fc=%h want 0/%h/0", imem_req, pc,
                     FunctionCode, RESET_PC);
        else n_pass++;
        n_chk++;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        imem_ack = 1'b0;
        if (fetch_done !== 1'b0 || imem_req !== 1'b0 || protocol_err !== 1'b0)
            $display("FAIL rstmid.late_ack: done=%b req=%b perr=%b want 0/0/0", fetch_done,
                     imem_req, protocol_err);
        else n_pass++;
        n_chk++;
        model_first = 1'b1;
        model_pc = RESET_PC;
        model_ir = 32'h0;
        // Decode while IDLE is a protocol error and leaves the decode outputs alone.
        en_instruction_decode = 1'b1;
        @(posedge clock); #1;
        en_instruction_decode = 1'b0;
        if (protocol_err !== 1'b1 || FunctionCode !== 6'h0 || imm_ext !== 32'h0)
            $display("FAIL idle_dec: perr=%b fc=%h imm=%h want 1/0/0", protocol_err,
                     FunctionCode, imm_ext);
        else n_pass++;
        n_chk++;
        return_addr = 32'h55;
        do_fetch(2'd3, 32'h0C40_2005, 0, 1'b0, 1'b0, 1'b0, "refetch");
    endtask

`ifdef FDU_ILLEGAL_TRAP_EN
    task automatic test_illegal;
        do_fetch(2'd0, 32'hFC00_0123, 0, 1'b0, 1'b0, 1'b0, "illegal");
        do_decode(1'b0, "illegal.dec");
        if (FunctionCode !== OP_NOP || illegal_op !== 1'b1)
            $display("FAIL illegal.nop: fc=%h ill=%b want %h/1", FunctionCode, illegal_op, OP_NOP);
        else n_pass++;
        n_chk++;
        do_fetch(2'd0, 32'h0C40_2005, 0, 1'b0, 1'b0, 1'b0, "legal");
        do_decode(1'b0, "legal.dec");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_imm_ext();
        test_pc_src();
        test_wait_protocol();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef FDU_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        if (addr_sb.size() != 0 || dec_sb.size() != 0) begin
            $display("FAIL scoreboard.drain: %0d addr, %0d decode left", addr_sb.size(),
                     dec_sb.size());
        end else n_pass++;
        n_chk++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
